// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder feeding a DEPTH-entry FIFO of decoded control
// bundles. Fetch and execute each use a valid/ready handshake. The block also
// has a single-source load-use interlock and a synchronous flush.
// Optional feature: define DECODE_SLT_EN to decode SLT/SLTU/SLTI/SLTIU as
// alu_op 8/9. When it is not defined, those encodings are flagged illegal.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [31:0]              out_imm,
  output logic [3:0]               out_alu_op,
  output logic [1:0]               out_alu_src,
  output logic [1:0]               out_branch_sel,
  output logic [2:0]               out_brcmp_src,
  output logic                     out_mr_sel,
  output logic                     out_mtr_sel,
  output logic                     out_mw_sel,
  output logic                     out_rw_sel,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int LAT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

`ifdef DECODE_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_XOR  = 4'd3,
    ALU_SRL = 4'd4, ALU_SRA = 4'd5, ALU_OR  = 4'd6, ALU_AND  = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {SRC_RF = 2'd0, SRC_SE = 2'd1, SRC_ZE = 2'd2} alu_src_e;

  typedef enum logic [1:0] {
    BS_NONE = 2'd0, BS_BRANCH = 2'd1, BS_JAL = 2'd2, BS_JALR = 2'd3
  } branch_sel_e;

  typedef enum logic [2:0] {
    BC_EQ = 3'd0, BC_NE = 3'd1, BC_LT = 3'd2, BC_GE = 3'd3,
    BC_LTU = 3'd4, BC_GEU = 3'd5, BC_NONE = 3'd7
  } brcmp_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    alu_op_e         alu_op;
    alu_src_e        alu_src;
    branch_sel_e     branch_sel;
    brcmp_e          brcmp;
    logic            mr;
    logic            mtr;
    logic            mw;
    logic            rw;
    logic            illegal;
    logic            use_rs1;
    logic            use_rs2;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LAT_W-1:0] haz_cnt;
  logic [4:0]      haz_rd;
  logic            push;
  logic            pop;
  logic            hazard;
  logic            op_ok;
  alu_op_e         op_sel;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Combinational decode of the incoming instruction into a FIFO entry.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    dec            = '0;
    dec.pc         = in_pc;
    dec.rd         = in_instr[11:7];
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.alu_op     = ALU_ADD;
    dec.alu_src    = SRC_RF;
    dec.branch_sel = BS_NONE;
    dec.brcmp      = BC_NONE;
    op_ok          = 1'b1;
    op_sel         = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  op_sel = ALU_ADD;
            3'b001:  op_sel = ALU_SLL;
            3'b010:  begin op_sel = SLT_EN ? ALU_SLT  : ALU_ADD; op_ok = SLT_EN; end
            3'b011:  begin op_sel = SLT_EN ? ALU_SLTU : ALU_ADD; op_ok = SLT_EN; end
            3'b100:  op_sel = ALU_XOR;
            3'b101:  op_sel = ALU_SRL;
            3'b110:  op_sel = ALU_OR;
            default: op_sel = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          op_sel = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          op_sel = ALU_SRA;
        end else begin
          op_ok = 1'b0;
        end
        if (op_ok) begin
          dec.alu_op = op_sel;
          dec.rw     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.use_rs1 = 1'b1;
        case (funct3)
          3'b000:  op_sel = ALU_ADD;
          3'b001:  op_sel = ALU_SLL;
          3'b010:  begin op_sel = SLT_EN ? ALU_SLT  : ALU_ADD; op_ok = SLT_EN; end
          3'b011:  begin op_sel = SLT_EN ? ALU_SLTU : ALU_ADD; op_ok = SLT_EN; end
          3'b100:  op_sel = ALU_XOR;
          3'b101:  op_sel = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  op_sel = ALU_OR;
          default: op_sel = ALU_AND;
        endcase
        if (op_ok) begin
          dec.alu_op  = op_sel;
          dec.alu_src = SRC_SE;
          dec.rw      = 1'b1;
          dec.imm     = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.use_rs1 = 1'b1;
        dec.mr      = 1'b1;
        dec.mtr     = 1'b1;
        dec.rw      = 1'b1;
        dec.alu_src = SRC_SE;
        dec.imm     = imm_i;
      end
      OPC_STORE: begin
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.mw      = 1'b1;
        dec.alu_src = SRC_SE;
        dec.imm     = imm_s;
      end
      OPC_BRANCH: begin
        dec.use_rs1    = 1'b1;
        dec.use_rs2    = 1'b1;
        dec.branch_sel = BS_BRANCH;
        dec.alu_op     = ALU_SUB;
        dec.imm        = imm_b;
        case (funct3)
          3'b000:  dec.brcmp = BC_EQ;
          3'b001:  dec.brcmp = BC_NE;
          3'b100:  dec.brcmp = BC_LT;
          3'b101:  dec.brcmp = BC_GE;
          3'b110:  dec.brcmp = BC_LTU;
          3'b111:  dec.brcmp = BC_GEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.branch_sel = BS_JAL;
        dec.rw         = 1'b1;
        dec.imm        = imm_j;
      end
      OPC_JALR: begin
        dec.use_rs1    = 1'b1;
        dec.branch_sel = BS_JALR;
        dec.rw         = 1'b1;
        dec.alu_src    = SRC_SE;
        dec.imm        = imm_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.rw      = 1'b1;
        dec.alu_src = SRC_ZE;
        dec.imm     = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign head      = mem[rd_ptr];
  assign in_ready  = (count < CW'(DEPTH));
  assign hazard    = (haz_cnt != '0) &&
                     ((head.use_rs1 && head.rs1 == haz_rd) ||
                      (head.use_rs2 && head.rs2 == haz_rd));
  assign out_valid = (count != '0) && !hazard && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Entry storage; written at the tail on every accepted push.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is cleared on reset so out_* read zero before the first push.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Read/write pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Load-use interlock: remember the destination of an issued load for LOAD_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      haz_cnt <= '0;
      haz_rd  <= '0;
    end else if (flush) begin
      haz_cnt <= '0;
    end else if (pop && head.mr && head.rd != 5'd0) begin
      haz_cnt <= LAT_W'(LOAD_LAT);
      haz_rd  <= head.rd;
    end else if (haz_cnt != '0) begin
      haz_cnt <= haz_cnt - LAT_W'(1);
    end
  end

  assign out_pc         = head.pc;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_imm        = head.imm;
  assign out_alu_op     = head.alu_op;
  assign out_alu_src    = head.alu_src;
  assign out_branch_sel = head.branch_sel;
  assign out_brcmp_src  = head.brcmp;
  assign out_mr_sel     = head.mr;
  assign out_mtr_sel    = head.mtr;
  assign out_mw_sel     = head.mw;
  assign out_rw_sel     = head.rw;
  assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_decode_queue;

  localparam int DEPTH    = 4;
  localparam int PC_W     = 32;
  localparam int LOAD_LAT = 1;

`ifdef DECODE_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_SW   = 32'h0020A423;  // sw x2,8(x1)
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;  // beq x0,x0,-4
  localparam logic [31:0] I_LW   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_DEP  = 32'h00528333;  // add x6,x5,x5
  localparam logic [31:0] I_IND  = 32'h00738333;  // add x6,x7,x7
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;  // slt x3,x1,x2
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]          in_instr, out_imm;
  logic [PC_W-1:0]      in_pc, out_pc;
  logic [4:0]           out_rd, out_rs1, out_rs2;
  logic [3:0]           out_alu_op;
  logic [1:0]           out_alu_src, out_branch_sel;
  logic [2:0]           out_brcmp_src;
  logic                 out_mr_sel, out_mtr_sel, out_mw_sel, out_rw_sel, out_illegal;
  logic [$clog2(DEPTH):0] count;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
    .out_branch_sel(out_branch_sel), .out_brcmp_src(out_brcmp_src),
    .out_mr_sel(out_mr_sel), .out_mtr_sel(out_mtr_sel), .out_mw_sel(out_mw_sel),
    .out_rw_sel(out_rw_sel), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [1:0]  bsel;
    logic [2:0]  brc;
    logic        mr, mtr, mw, rw, ill;
  } exp_t;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } item_t;

  // Expected control bundle from the RV32I encoding rules.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    int   alu_tab[8];
    int   brc_tab[8];
    int   a;
    logic [2:0] f3;
    logic [6:0] f7;
    alu_tab = '{0, 2, 8, 9, 3, 4, 6, 7};
    brc_tab = '{0, 1, 7, 7, 2, 3, 4, 5};
    f3 = i[14:12];
    f7 = i[31:25];
    e = '0;
    e.brc = 3'd7;
    case (i[6:0])
      7'h33: begin
        a = -1;
        if (f7 == 7'h00) a = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) a = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) a = 5;
        if (a >= 8 && !SLT_EN) a = -1;
        if (a < 0) e.ill = 1'b1;
        else begin e.alu = 4'(a); e.rw = 1'b1; end
      end
      7'h13: begin
        a = alu_tab[f3];
        if (f3 == 3'd5 && i[30]) a = 5;
        if (a >= 8 && !SLT_EN) a = -1;
        if (a < 0) e.ill = 1'b1;
        else begin
          e.alu = 4'(a); e.src = 2'd1; e.rw = 1'b1;
          e.imm = 32'($signed(i[31:20]));
        end
      end
      7'h03: begin
        e.mr = 1'b1; e.mtr = 1'b1; e.rw = 1'b1; e.src = 2'd1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h23: begin
        e.mw = 1'b1; e.src = 2'd1;
        e.imm = 32'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        e.bsel = 2'd1; e.alu = 4'd1;
        e.brc = 3'(brc_tab[f3]);
        e.ill = (brc_tab[f3] == 7);
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h6F: begin
        e.bsel = 2'd2; e.rw = 1'b1;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin
        e.bsel = 2'd3; e.rw = 1'b1; e.src = 2'd1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h37, 7'h17: begin
        e.rw = 1'b1; e.src = 2'd2;
        e.imm = {i[31:12], 12'h000};
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic bit uses_rs1(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit uses_rs2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  item_t q[$];
  int    cyc      = 0;
  int    load_cyc = -1000;
  logic [4:0] load_rd = '0;
  bit    exp_valid, exp_hz, m_push, m_pop;
  exp_t  he;
  item_t hi;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      load_cyc = -1000;
    end else begin
      exp_hz = 1'b0;
      if (q.size() > 0 && (cyc - load_cyc) >= 1 && (cyc - load_cyc) <= LOAD_LAT)
        exp_hz = (uses_rs1(q[0].instr) && q[0].instr[19:15] == load_rd) ||
                 (uses_rs2(q[0].instr) && q[0].instr[24:20] == load_rd);
      exp_valid = (q.size() > 0) && !exp_hz && !flush;
      check("count", 64'(count), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      if (q.size() > 0) begin
        hi = q[0];
        he = ref_decode(hi.instr);
        check("out_pc", 64'(out_pc), 64'(hi.pc));
        check("regs", 64'({out_rd, out_rs1, out_rs2}),
              64'({hi.instr[11:7], hi.instr[19:15], hi.instr[24:20]}));
        check("imm", 64'(out_imm), 64'(he.imm));
        check("ctrl",
              64'({out_alu_op, out_alu_src, out_branch_sel, out_brcmp_src,
                   out_mr_sel, out_mtr_sel, out_mw_sel, out_rw_sel, out_illegal}),
              64'({he.alu, he.src, he.bsel, he.brc, he.mr, he.mtr, he.mw, he.rw, he.ill}));
      end
      m_push = in_valid && (q.size() < DEPTH) && !flush;
      m_pop  = exp_valid && out_ready;
      if (flush) begin
        q.delete();
        load_cyc = -1000;
      end else begin
        if (m_pop) begin
          hi = q.pop_front();
          if (hi.instr[6:0] == 7'h03 && hi.instr[11:7] != 5'd0) begin
            load_cyc = cyc;
            load_rd  = hi.instr[11:7];
          end
        end
        if (m_push) q.push_back('{instr: in_instr, pc: in_pc});
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  logic [PC_W-1:0] pc = 32'h0000_1000;

  // Apply one cycle of inputs and return 1 time unit after the clock edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
    pc = pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops[9];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    r[6:0]   = ops[$urandom_range(0, 8)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
      r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [PC_W-1:0] base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'({out_pc, out_imm}), 64'd0);

    // Basic decode and one-cycle latency.
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_ctrl", 64'({out_alu_op, out_alu_src, out_rw_sel, out_rd}), 64'({4'd0, 2'd0, 1'b1, 5'd3}));
    drive(1'b1, I_SW, 1'b1, 1'b0);
    check("sw_imm", 64'(out_imm), 64'h0000_0008);
    check("sw_ctrl", 64'({out_mw_sel, out_alu_src}), 64'({1'b1, 2'd1}));
    drive(1'b1, I_BEQ, 1'b1, 1'b0);
    check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check("beq_ctrl", 64'({out_brcmp_src, out_branch_sel}), 64'({3'd0, 2'd1}));
    drive(1'b0, '0, 1'b1, 1'b0);

    // Fill with execute stalled, then drain in order.
    base = pc;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, I_IND, 1'b0, 1'b0);
      if (k == 3) check("full_in_ready", 64'(in_ready), 64'd0);
    end
    check("full_count", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", 64'(out_pc), 64'(base + PC_W'(4 * k)));
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_count", 64'(count), 64'd0);

    // Load-use stall for one cycle.
    drive(1'b1, I_LW, 1'b0, 1'b0);
    drive(1'b1, I_DEP, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("lu_stall", 64'(out_valid), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("lu_release", 64'(out_valid), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Independent head after a load: no stall.
    drive(1'b1, I_LW, 1'b0, 1'b0);
    drive(1'b1, I_IND, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("lu_nostall", 64'(out_valid), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Flush with three entries and the interlock active.
    drive(1'b1, I_LW, 1'b0, 1'b0);
    drive(1'b1, I_DEP, 1'b0, 1'b0);
    drive(1'b1, I_IND, 1'b0, 1'b0);
    drive(1'b1, I_IND, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    check("fl_pre_count", 64'(count), 64'd3);
    check("fl_pre_hazard", 64'(out_valid), 64'd0);
    drive(1'b1, I_ADD, 1'b1, 1'b1);
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    drive(1'b1, I_DEP, 1'b0, 1'b0);
    check("fl_hz_clear", 64'(out_valid), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);

    // SLT configuration and an unknown opcode.
    drive(1'b1, I_SLT, 1'b0, 1'b0);
    check("slt_op", 64'({out_alu_op, out_illegal}), SLT_EN ? 64'({4'd8, 1'b0}) : 64'({4'd0, 1'b1}));
    drive(1'b1, I_BAD, 1'b1, 1'b0);
    check("bad_ctrl", 64'({out_illegal, out_brcmp_src}), 64'({1'b1, 3'd7}));
    drive(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic, with occasional flush and mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
      end
      drive(($urandom_range(0, 9) < 7), rand_instr(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 39) == 0));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
